// File: rtl/bcd_sub_seq.sv
// Sequential BCD subtractor: a - b - bin, one decimal digit per clock, LSD first.
// Optional input-digit range checking is enabled with `define BCD_SUB_ERR_CHK_EN.
module bcd_sub_seq #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  bout,
  output logic                  err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic               br_q;
  logic [IDX_W-1:0]   idx_q;
  logic [W-1:0]       diff_q;
  logic [W-1:0]       diff_d;
  logic               bout_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic [3:0]         a_dig;
  logic [3:0]         b_dig;
  logic [4:0]         sub_res;
  logic               last_dig;

  // One ten's-complement digit step; returns {borrow_out, digit}.
  function automatic logic [4:0] digit_sub(input logic [3:0] ai,
                                           input logic [3:0] bi,
                                           input logic       br);
    logic [4:0] raw;
    raw = {1'b0, ai} - {1'b0, bi} - {4'b0000, br};
    if (raw[4])
      digit_sub = {1'b1, raw[3:0] + 4'd10};
    else
      digit_sub = {1'b0, raw[3:0]};
  endfunction

  always_comb begin
    a_dig = 4'h0;
    b_dig = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
  end

  assign sub_res  = digit_sub(a_dig, b_dig, br_q);
  assign last_dig = (idx_q == IDX_W'(DIGITS - 1));

  // Only the digit at idx_q is replaced; the rest of the result is kept.
  always_comb begin
    diff_d = diff_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i))
        diff_d[4*i +: 4] = sub_res[3:0];
    end
  end

`ifdef BCD_SUB_ERR_CHK_EN
  logic err_q;
  logic dig_bad;

  assign dig_bad = (a_dig > 4'd9) | (b_dig > 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      err_q <= 1'b0;
    end else if (state_q == CALC) begin
      err_q <= err_q | dig_bad;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      br_q        <= 1'b0;
      idx_q       <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            br_q       <= bin;
            idx_q      <= '0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          diff_q <= diff_d;
          br_q   <= sub_res[4];
          idx_q  <= idx_q + IDX_W'(1);
          if (last_dig) begin
            bout_q      <= sub_res[4];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // in_ready rises only after the output handshake edge.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_bcd_sub_seq.sv
// Directed, scoreboarded bench for bcd_sub_seq with DIGITS=2.
module tb_bcd_sub_seq;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         err;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         err;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  bcd_sub_seq #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: signed integer digit arithmetic with decimal borrow.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic bi);
    exp_t r;
    int   br;
    int   raw;
    int   ad;
    int   bd;
    logic [31:0] rv;
    r  = '0;
    br = int'(bi);
    for (int i = 0; i < DIGITS; i++) begin
      ad  = int'(av[4*i +: 4]);
      bd  = int'(bv[4*i +: 4]);
      raw = ad - bd - br;
      if (raw < 0) begin
        raw = raw + 10;
        br  = 1;
      end else begin
        br  = 0;
      end
      rv = 32'(raw);
      r.diff[4*i +: 4] = rv[3:0];
`ifdef BCD_SUB_ERR_CHK_EN
      if (ad > 9 || bd > 9) r.err = 1'b1;
`endif
    end
    r.bout = (br != 0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an operand set and wait for the accept edge; result goes on the scoreboard.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    bit ok;
    ok = 0;
    @(negedge clk);
    a        = av;
    b        = bv;
    bin      = bi;
    in_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      sb_q.push_back(model(av, bv, bi));
    end
    #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    bin      = 1'($urandom);
  endtask

  // Wait for the result (called #1 after the accept edge), compare, optionally stall, then handshake.
  task automatic recv(input string tag, input int stall);
    int   cyc;
    exp_t e;
    logic [W-1:0] held;
    cyc = 0;
    while (!out_valid && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!out_valid) chk({tag, "_inready_calc"}, 32'(in_ready), 32'd0);
    end
    if (!out_valid) begin
      chk({tag, "_outvalid_timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(DIGITS));
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_diff"}, 32'(diff), 32'(e.diff));
    chk({tag, "_bout"}, 32'(bout), 32'(e.bout));
    chk({tag, "_err"},  32'(err),  32'(e.err));
    chk({tag, "_inready_done"}, 32'(in_ready), 32'd0);
    held = diff;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_diff"},   32'(diff),      32'(held));
      chk({tag, "_hold_valid"},  32'(out_valid), 32'd1);
      chk({tag, "_hold_inrdy"},  32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_post_inrdy"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_inready",  32'(in_ready),  32'd1);
    chk("rst_outvalid", 32'(out_valid), 32'd0);
    chk("rst_diff",     32'(diff),      32'd0);
    chk("rst_bout",     32'(bout),      32'd0);
    chk("rst_err",      32'(err),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    send(8'h45, 8'h17, 1'b0);  recv("s45_17", 0);
    send(8'h03, 8'h05, 1'b0);  recv("s03_05", 0);
    send(8'h00, 8'h00, 1'b1);  recv("s00_00b", 0);
    send(8'h99, 8'h99, 1'b0);  recv("s99_99", 0);
    send(8'h50, 8'h49, 1'b1);  recv("s50_49b", 0);
    send(8'h72, 8'h38, 1'b0);  recv("bp72_38", 5);

    // Abort during the first CALC digit.
    send(8'h45, 8'h17, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_outvalid", 32'(out_valid), 32'd0);
    chk("abort_diff",     32'(diff),      32'd0);
    chk("abort_bout",     32'(bout),      32'd0);
    chk("abort_inready",  32'(in_ready),  32'd1);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DIGITS + 2; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_result", 32'(out_valid), 32'd0);
    end
    send(8'h10, 8'h01, 1'b0);  recv("s10_01", 0);

    send(8'hA3, 8'h01, 1'b0);  recv("illegal_A3", 0);
    send(8'h21, 8'h12, 1'b0);  recv("legal_after", 0);

    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      for (int d = 0; d < DIGITS; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(0, 9));
        rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      send(ra, rb, 1'($urandom));
      recv("rand", i % 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
